// File: rtl/serial_sub5.sv
// Bit-serial WIDTH-bit subtractor D = X - Y, LSB first, one bit per clock through a single full-adder cell.
// Optional signed-overflow output V when SERIAL_SUB5_OVF_EN is defined.
module serial_sub5 #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB5_OVF_EN
  output logic             V,
`endif
  output logic             B5
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_xs, r_ys;
  // Holds the low WIDTH-1 result bits; the final bit goes straight into D.
  logic [WIDTH-2:0]   r_res;

  logic w_load, w_shift, w_last;
  logic w_nb, w_s, w_cout;

  // X + ~Y + 1 through one full-adder cell
  assign w_nb   = ~r_ys[0];
  assign w_s    = r_xs[0] ^ w_nb ^ r_carry;
  assign w_cout = (r_xs[0] & w_nb) | (r_xs[0] & r_carry) | (w_nb & r_carry);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIN;
      FIN:     w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load  = ((r_state == IDLE) || (r_state == FIN)) && start;
    w_shift = (r_state == SHIFT);
    w_last  = w_shift && (r_cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_xs    <= '0;
      r_ys    <= '0;
      r_res   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      D       <= '0;
      B5      <= 1'b0;
`ifdef SERIAL_SUB5_OVF_EN
      V       <= 1'b0;
`endif
    end else if (w_load) begin
      r_xs    <= X;
      r_ys    <= Y;
      r_carry <= 1'b1;
      r_cnt   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (w_shift) begin
      r_xs    <= r_xs >> 1;
      r_ys    <= r_ys >> 1;
      r_carry <= w_cout;
      r_res   <= {w_s, r_res[WIDTH-2:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        D    <= {w_s, r_res};
        B5   <= ~w_cout;
        busy <= 1'b0;
        done <= 1'b1;
`ifdef SERIAL_SUB5_OVF_EN
        V    <= r_carry ^ w_cout;
`endif
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_sub5.sv
// Directed bench for serial_sub5: latency, arithmetic, ignored start, abort by reset, back-to-back.
// Checks V as well when SERIAL_SUB5_OVF_EN is defined.
module tb_serial_sub5;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] X, Y, D;
  logic       busy, done, B5;
`ifdef SERIAL_SUB5_OVF_EN
  logic       V;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_sub5 dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .D(D),
`ifdef SERIAL_SUB5_OVF_EN
    .V(V),
`endif
    .B5(B5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start an op at a negedge; if gl>0, pulse start with X=Y=1 during SHIFT cycle gl.
  // Returns at the negedge after the done cycle.
  task automatic run_op(input logic [4:0] x, input logic [4:0] y,
                        input logic [4:0] ed, input logic eb, input int gl);
    X = x; Y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; X = 5'd0; Y = 5'd0;
    chk("busy_on", busy, 1);
    for (int i = 1; i < 5; i++) begin
      if (i == gl) begin start = 1'b1; X = 5'd1; Y = 5'd1; end
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid", busy, 1);
      chk("no_early_done", done, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_off", busy, 0);
    chk("D", D, ed);
    chk("B5", B5, eb);
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("D_hold", D, ed);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_B5", B5, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(5'd20, 5'd7,  5'd13, 1'b0, 0);
    run_op(5'd7,  5'd20, 5'd19, 1'b1, 0);
    run_op(5'd31, 5'd31, 5'd0,  1'b0, 0);
    run_op(5'd0,  5'd1,  5'd31, 1'b1, 0);
    run_op(5'd9,  5'd0,  5'd9,  1'b0, 0);
    run_op(5'd10, 5'd3,  5'd7,  1'b0, 2);

    // reset aborts mid-SHIFT
    X = 5'd25; Y = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_D", D, 0);
    chk("abort_B5", B5, 0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", seen, 0);

    // start and rst together: rst wins
    rst = 1'b1; start = 1'b1; X = 5'd4; Y = 5'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("rst_start_nodone", done, 0);

    // back-to-back with start held high
    X = 5'd5; Y = 5'd2; start = 1'b1;
    @(negedge clk);
    X = 5'd2; Y = 5'd5;
    repeat (4) @(negedge clk);
    chk("b2b_busy1", busy, 1);
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_D1", D, 3);
    chk("b2b_B1", B5, 0);
    @(negedge clk);
    chk("b2b_restart", busy, 1);
    chk("b2b_gap", done, 0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_Dhold", D, 3);
    chk("b2b_nodone", done, 0);
    @(negedge clk);
    chk("b2b_done2", done, 1);
    chk("b2b_D2", D, 29);
    chk("b2b_B2", B5, 1);
    @(negedge clk);

`ifdef SERIAL_SUB5_OVF_EN
    run_op(5'd15, 5'd16, 5'd31, 1'b1, 0);
    chk("V_ovf", V, 1);
    run_op(5'd3, 5'd1, 5'd2, 1'b0, 0);
    chk("V_none", V, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub5.md
Name: serial_sub5

Overview:
- Bit-serial 5-bit subtractor computing D = X - Y, LSB first, one bit per clock, through a single full-adder cell with a registered carry.
- Companion to the 5-bit ripple adder: it covers the subtraction direction and uses the same X/Y/result/top-bit naming, with borrow instead of carry.
- Used where area matters more than latency. Start/done handshake to the controlling logic.

Parameters:
- WIDTH, 5, operand/result width in bits; also the number of SHIFT cycles.
- CNT_W, 3, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE or DONE.
- X  input  WIDTH  minuend, unsigned; latched on accepted start.
- Y  input  WIDTH  subtrahend, unsigned; latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; D/B5 valid from this cycle onward.
- D  output  WIDTH  difference, X - Y mod 2^WIDTH.
- B5  output  1  borrow out; 1 iff X < Y (unsigned).

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high. rst has priority over all other inputs.
- Reset values: busy=0, done=0, D=0, B5=0. Internal state: state=IDLE, counter=0, carry=0, shift registers=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: processes WIDTH bits.
  - DONE: one cycle; asserts done.
- IDLE -> SHIFT when start=1. On that edge:
  - latch X into xs and Y into ys.
  - set carry=1 (two's-complement +1).
  - set counter=0 and busy=1.
- SHIFT, each edge:
  - Form the bit from xs[0] and ys[0]: s = xs[0] ^ ~ys[0] ^ carry.
  - Next carry = majority(xs[0], ~ys[0], carry).
  - Shift xs and ys right by one.
  - Shift s into the result register at the MSB end, so the result register fills LSB-first.
  - Increment counter.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1). On that same edge:
  - D <= completed result.
  - B5 <= ~final carry.
  - busy <= 0.
  - done <= 1.
- DONE -> IDLE on the next edge; done returns to 0. If start=1 in DONE, go directly to SHIFT instead, with the same latch actions as IDLE.
- Latency: start sampled at edge N. busy is high in cycles N+1..N+5. done is high in cycle N+6 only, as seen after edges N+5..N+6. Throughput is one operation per 6 cycles.
- D and B5 hold their value from done until the next completion. They do not change during a following SHIFT.
- start while busy is ignored: no restart and no relatch. X and Y may change freely after the accepting edge.
- rst asserted mid-SHIFT aborts the operation: state=IDLE, all outputs return to reset values on that edge, and no done pulse is produced.
- start and rst high in the same cycle: rst wins; the block stays in IDLE.
- Arithmetic:
  - X=Y gives D=0, B5=0.
  - Y=0 gives D=X, B5=0.
  - Wrap-around is mod 2^WIDTH; B5 reports the wrap.

Optional Feature:
- Macro: SERIAL_SUB5_OVF_EN.
- Defined:
  - Adds output port V (1 bit), treating X and Y as signed two's complement.
  - V <= carry into the MSB cell XOR carry out of the MSB cell, captured on the same edge as D.
  - Reset value 0; held like D.
- Undefined: port V and its capture register are absent; all other behaviour is identical.

Test Plan:
- X=20, Y=7, start pulse -> busy high for 5 cycles, then done pulse; D=13 (01101), B5=0.
- X=7, Y=20 -> D=19 (10011), B5=1. Then X=31, Y=31 -> D=0, B5=0. Then X=0, Y=1 -> D=31, B5=1.
- Start X=10, Y=3; at SHIFT cycle 2 pulse start with X=1, Y=1 -> ignored; result D=7, B5=0; done exactly 6 cycles after the first start.
- Start X=25, Y=9; rst=1 at SHIFT cycle 3 -> next edge busy=0, done=0, D=0, B5=0; no done pulse for the following 10 cycles.
- Back-to-back: hold start=1 continuously with X=5, Y=2, then X=2, Y=5 -> done pulses every 6 cycles; D=3/B5=0, then D=29/B5=1.
- With SERIAL_SUB5_OVF_EN:
  - X=15, Y=16 (signed -16) -> D=31, B5=1, V=1.
  - X=3, Y=1 -> D=2, V=0.
